// File: rtl/cal_burst_seq.sv
// Calibration burst sequencer: issues a programmable FINJ/FPLS strobe train on START,
// then drains while counting the CAL_GTRG pulses returned by the trigger stage.
//
// state | meaning
// IDLE  | waiting for START, outputs hold the last burst's result
// HIGH  | selected strobe driven high for PLSWIDTH+1 clocks
// GAP   | strobe low until the period since its leading edge expires
// DRAIN | strobes low, waiting DRAIN_CLKS clocks for trailing triggers
module cal_burst_seq #(
  parameter int unsigned MIN_SPACING = 32,
  parameter int unsigned DRAIN_CLKS  = 255,
  parameter int unsigned TMR         = 0
) (
  input  logic        CLKCMS,
  input  logic        RST_B,
  input  logic        START,
  input  logic        ABORT,
  input  logic [1:0]  MODE,
  input  logic [7:0]  NPULSE,
  input  logic [11:0] SPACING,
  input  logic [2:0]  PLSWIDTH,
  input  logic        CAL_GTRG,
  output logic        FINJ,
  output logic        FPLS,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  PCOUNT,
  output logic [7:0]  GTRG_CNT,
  output logic        MISSED
);

  localparam int unsigned TW = ($clog2(DRAIN_CLKS + 1) > 12) ? $clog2(DRAIN_CLKS + 1) : 12;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2, DRAIN = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr_q, tmr_nxt;
  logic [2:0]      wid_q, wid_nxt;
  logic [1:0]      mode_q;
  logic [7:0]      npulse_q;
  logic [2:0]      wcfg_q;
  logic [11:0]     period_q, period_in;
  logic            sel_pls_q, sel_pls_nxt;
  logic            finj_nxt, fpls_nxt, busy_nxt, done_nxt, missed_nxt;
  logic [7:0]      pcount_nxt, gtrg_nxt;
  logic            ld_cfg;

  assign period_in = (SPACING < 12'(MIN_SPACING)) ? 12'(MIN_SPACING) : SPACING;

  // odd = 1 for the 1st, 3rd, ... strobe of the burst
  function automatic logic pick_pls(input logic [1:0] mode, input logic odd);
    return (mode == 2'd1) || ((mode == 2'd2) && !odd);
  endfunction

  if (TMR != 0) begin : g_tmr
    state_t s0, s1, s2;
    always_ff @(posedge CLKCMS or negedge RST_B) begin
      if (!RST_B) begin
        s0 <= IDLE;
        s1 <= IDLE;
        s2 <= IDLE;
      end else begin
        s0 <= state_nxt;
        s1 <= state_nxt;
        s2 <= state_nxt;
      end
    end
    assign state = state_t'((s0 & s1) | (s0 & s2) | (s1 & s2));
  end else begin : g_simplex
    state_t s_q;
    always_ff @(posedge CLKCMS or negedge RST_B) begin
      if (!RST_B) s_q <= IDLE;
      else        s_q <= state_nxt;
    end
    assign state = s_q;
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = (tmr_q == '0) ? '0 : tmr_q - TW'(1);
    wid_nxt     = (wid_q == 3'd0) ? 3'd0 : wid_q - 3'd1;
    sel_pls_nxt = sel_pls_q;
    finj_nxt    = 1'b0;
    fpls_nxt    = 1'b0;
    busy_nxt    = BUSY;
    done_nxt    = 1'b0;
    pcount_nxt  = PCOUNT;
    missed_nxt  = MISSED;
    ld_cfg      = 1'b0;
    gtrg_nxt    = (BUSY && CAL_GTRG && (GTRG_CNT != 8'hFF)) ? GTRG_CNT + 8'd1 : GTRG_CNT;

    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          ld_cfg      = 1'b1;
          state_nxt   = HIGH;
          busy_nxt    = 1'b1;
          pcount_nxt  = 8'd1;
          gtrg_nxt    = 8'd0;
          missed_nxt  = 1'b0;
          wid_nxt     = PLSWIDTH;
          tmr_nxt     = TW'(period_in) - TW'(1);
          sel_pls_nxt = pick_pls(MODE, 1'b1);
          finj_nxt    = !sel_pls_nxt;
          fpls_nxt    = sel_pls_nxt;
        end
      end
      HIGH: begin
        if (ABORT) begin
          state_nxt = DRAIN;
          tmr_nxt   = TW'(DRAIN_CLKS - 1);
        end else if (wid_q == 3'd0) begin
          state_nxt = GAP;
        end else begin
          finj_nxt = !sel_pls_q;
          fpls_nxt = sel_pls_q;
        end
      end
      GAP: begin
        if (ABORT || ((tmr_q == '0) && (npulse_q != 8'd0) && (PCOUNT == npulse_q))) begin
          state_nxt = DRAIN;
          tmr_nxt   = TW'(DRAIN_CLKS - 1);
        end else if (tmr_q == '0) begin
          state_nxt   = HIGH;
          pcount_nxt  = PCOUNT + 8'd1;
          wid_nxt     = wcfg_q;
          tmr_nxt     = TW'(period_q) - TW'(1);
          sel_pls_nxt = pick_pls(mode_q, !PCOUNT[0]);
          finj_nxt    = !sel_pls_nxt;
          fpls_nxt    = sel_pls_nxt;
        end
      end
      DRAIN: begin
        if (tmr_q == '0) begin
          state_nxt  = IDLE;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          missed_nxt = (PCOUNT != gtrg_nxt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKCMS or negedge RST_B) begin
    if (!RST_B) begin
      tmr_q     <= '0;
      wid_q     <= 3'd0;
      sel_pls_q <= 1'b0;
      mode_q    <= 2'd0;
      npulse_q  <= 8'd0;
      wcfg_q    <= 3'd0;
      period_q  <= 12'd0;
      FINJ      <= 1'b0;
      FPLS      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PCOUNT    <= 8'd0;
      GTRG_CNT  <= 8'd0;
      MISSED    <= 1'b0;
    end else begin
      tmr_q     <= tmr_nxt;
      wid_q     <= wid_nxt;
      sel_pls_q <= sel_pls_nxt;
      FINJ      <= finj_nxt;
      FPLS      <= fpls_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      PCOUNT    <= pcount_nxt;
      GTRG_CNT  <= gtrg_nxt;
      MISSED    <= missed_nxt;
      if (ld_cfg) begin
        mode_q   <= MODE;
        npulse_q <= NPULSE;
        wcfg_q   <= PLSWIDTH;
        period_q <= period_in;
      end
    end
  end

endmodule

// File: tb/tb_cal_burst_seq.sv
// Bench for cal_burst_seq: directed and randomized bursts checked cycle by cycle
// against an arithmetic schedule of strobes, triggers and completion.
module tb_cal_burst_seq;

  localparam int MIN_SP = 32;
  localparam int DRN    = 255;

  logic        CLKCMS = 1'b0;
  logic        RST_B = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [1:0]  MODE = 2'd0;
  logic [7:0]  NPULSE = 8'd0;
  logic [11:0] SPACING = 12'd0;
  logic [2:0]  PLSWIDTH = 3'd0;
  logic        CAL_GTRG = 1'b0;
  logic        FINJ, FPLS, BUSY, DONE, MISSED;
  logic [7:0]  PCOUNT, GTRG_CNT;

  int vectors = 0;
  int miscompares = 0;

  // burst description used by the reference schedule
  int m_mode, m_w, m_P, m_ntrig, m_issued, m_abort_t, m_drain, m_done;

  cal_burst_seq dut (
    .CLKCMS(CLKCMS), .RST_B(RST_B), .START(START), .ABORT(ABORT), .MODE(MODE),
    .NPULSE(NPULSE), .SPACING(SPACING), .PLSWIDTH(PLSWIDTH), .CAL_GTRG(CAL_GTRG),
    .FINJ(FINJ), .FPLS(FPLS), .BUSY(BUSY), .DONE(DONE), .PCOUNT(PCOUNT),
    .GTRG_CNT(GTRG_CNT), .MISSED(MISSED)
  );

  always #5 CLKCMS = ~CLKCMS;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {FINJ, FPLS, BUSY, DONE, PCOUNT, GTRG_CNT, MISSED};
  endfunction

  function automatic int trig_cycle(int j);
    return 2 + (j - 1) * m_P;
  endfunction

  function automatic logic is_trig(int t);
    return (t >= 2) && (((t - 2) % m_P) == 0) && (((t - 2) / m_P) < m_ntrig);
  endfunction

  // expected outputs in cycle t, where cycle 1 is the first cycle after START is sampled
  function automatic logic [20:0] expect_at(int t);
    logic inj, pls, busy, done, missed;
    logic [7:0] pc;
    int k, ntr;
    inj = 1'b0;
    pls = 1'b0;
    if (t < m_drain) begin
      k  = (t - 1) / m_P + 1;
      pc = 8'(k);
      if (((t - 1) % m_P) <= m_w) begin
        if (m_mode == 1 || (m_mode == 2 && (k % 2) == 0)) pls = 1'b1;
        else inj = 1'b1;
      end
    end else begin
      pc = 8'(m_issued);
    end
    ntr = 0;
    for (int j = 1; j <= m_ntrig; j++) if (trig_cycle(j) < t) ntr++;
    busy   = (t < m_done);
    done   = (t == m_done);
    missed = (t >= m_done) && ((m_issued % 256) != m_ntrig);
    return {inj, pls, busy, done, pc, 8'(ntr), missed};
  endfunction

  // abk: abort during the first cycle of strobe abk (0 = no abort)
  task automatic run_burst(input int mode, input int np, input int sp, input int w,
                           input int abk, input int ntrig, input bit spur);
    m_mode   = mode;
    m_w      = w;
    m_P      = (sp < MIN_SP) ? MIN_SP : sp;
    m_ntrig  = ntrig;
    m_issued = (abk != 0) ? abk : np;
    m_abort_t = (abk != 0) ? 1 + (abk - 1) * m_P : -1;
    m_drain  = (abk != 0) ? m_abort_t + 1 : 1 + np * m_P;
    m_done   = m_drain + DRN;
    @(negedge CLKCMS);
    MODE = 2'(mode); NPULSE = 8'(np); SPACING = 12'(sp); PLSWIDTH = 3'(w);
    START = 1'b1; ABORT = 1'b0; CAL_GTRG = 1'b0;
    for (int t = 1; t <= m_done + 3; t++) begin
      @(negedge CLKCMS);
      chk($sformatf("cyc%0d", t), 32'(outs()), 32'(expect_at(t)));
      chk("excl", 32'(FINJ & FPLS), 32'd0);
      START    = spur && (t == w + 3);
      ABORT    = (t == m_abort_t) || (t == m_done - 3) || (t == m_done + 1);
      CAL_GTRG = is_trig(t) || ((t >= m_done) && ($urandom_range(1) == 1));
      MODE     = 2'($urandom);
      NPULSE   = 8'($urandom);
      SPACING  = 12'($urandom);
      PLSWIDTH = 3'($urandom);
    end
    START = 1'b0; ABORT = 1'b0; CAL_GTRG = 1'b0;
  endtask

  initial begin
    @(negedge CLKCMS);
    chk("reset", 32'(outs()), 32'd0);
    RST_B = 1'b1;

    run_burst(0, 3, 100, 1, 0, 3, 1'b1);
    run_burst(2, 4, 10, 0, 0, 4, 1'b0);
    run_burst(1, 0, 40, 2, 5, 4, 1'b0);

    // START together with ABORT while idle is dropped
    @(negedge CLKCMS);
    START = 1'b1; ABORT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLKCMS);
      START = 1'b0; ABORT = 1'b0;
      chk("start_abort_idle", 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'd4, 1'b1}));
    end

    // reset in the middle of a strobe
    @(negedge CLKCMS);
    MODE = 2'd0; NPULSE = 8'd3; SPACING = 12'd50; PLSWIDTH = 3'd3; START = 1'b1;
    @(negedge CLKCMS);
    START = 1'b0;
    chk("rst_pre_finj", 32'(FINJ), 32'd1);
    #2 RST_B = 1'b0;
    #1 chk("rst_async", 32'(outs()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLKCMS);
      chk("rst_hold", 32'(outs()), 32'd0);
    end
    RST_B = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLKCMS);
      chk("rst_idle", 32'(outs()), 32'd0);
    end

    run_burst(0, 2, 33, 7, 0, 1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int mode, np, sp, w, abk, ntrig;
      mode  = (i == 0) ? 3 : $urandom_range(3, 0);
      np    = $urandom_range(6, 1);
      sp    = $urandom_range(120, 0);
      w     = $urandom_range(7, 0);
      abk   = ($urandom_range(1, 0) == 1) ? $urandom_range(np, 1) : 0;
      ntrig = $urandom_range((abk != 0) ? abk : np, 0);
      run_burst(mode, np, sp, w, abk, ntrig, $urandom_range(1, 0) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
